// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master.
// Mode (CPOL/CPHA), bit order, chip select and bit rate are captured when a
// transfer starts and held constant until it completes with a one-cycle done.
module spi_master_param #(
    parameter int DATA_WIDTH  = 8,
    parameter int PRESC_WIDTH = 8,
    parameter int NUM_CS      = 4,
    parameter int CS_SEL_W    = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   spi_start,
    input  logic [DATA_WIDTH-1:0]  spi_data_in,
    input  logic [PRESC_WIDTH-1:0] spi_prescaler,
    input  logic                   spi_cpol,
    input  logic                   spi_cpha,
    input  logic                   spi_lsb_first,
    input  logic [CS_SEL_W-1:0]    spi_cs_sel,
    input  logic                   MISO,
    output logic                   MOSI,
    output logic                   SCLK,
    output logic [NUM_CS-1:0]      CS_N,
    output logic [DATA_WIDTH-1:0]  spi_data_out,
    output logic                   busy,
    output logic                   done
);

    // Edge counter holds 0 .. 2*DATA_WIDTH-1 (zero-based SCLK edge index).
    localparam int EDGE_W = $clog2(2 * DATA_WIDTH);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LEAD,
        ST_XFER,
        ST_TRAIL
    } state_t;

    state_t                 state_q, state_d;
    logic [PRESC_WIDTH-1:0] cnt_q, cnt_d;
    logic [PRESC_WIDTH-1:0] presc_q, presc_d;
    logic [EDGE_W-1:0]      edge_q, edge_d;
    logic                   cpol_q, cpol_d;
    logic                   cpha_q, cpha_d;
    logic                   lsb_q, lsb_d;
    logic [DATA_WIDTH-1:0]  tx_q, tx_d;
    logic [DATA_WIDTH-1:0]  rx_q, rx_d;
    logic                   mosi_q, mosi_d;
    logic                   sclk_q, sclk_d;
    logic [NUM_CS-1:0]      cs_n_q, cs_n_d;
    logic [DATA_WIDTH-1:0]  data_out_q, data_out_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [NUM_CS-1:0]      cs_dec;
    logic                   tick;
    logic                   leading;
    logic                   sample_edge;

    // Bit that goes out next, given the current bit order.
    function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DATA_WIDTH-1];
    endfunction

    // Discard the bit just sent.
    function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] w,
                                                        input logic lsb);
        return lsb ? (w >> 1) : (w << 1);
    endfunction

    // Insert a received bit so that after DATA_WIDTH bits bit i is the slave's bit i.
    function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] r,
                                                       input logic b, input logic lsb);
        return lsb ? {b, r[DATA_WIDTH-1:1]} : {r[DATA_WIDTH-2:0], b};
    endfunction

    // One-hot-low chip-select decode; an out-of-range index selects nothing.
    generate
        for (genvar gi = 0; gi < NUM_CS; gi++) begin : g_cs
            assign cs_dec[gi] = (spi_cs_sel != CS_SEL_W'(gi));
        end
    endgenerate

    // Half-period tick plus classification of the SCLK edge it produces.
    always_comb begin
        tick        = (cnt_q == presc_q);
        leading     = ~edge_q[0];
        sample_edge = leading ^ cpha_q;
    end

    // Next-state and output logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        presc_d    = presc_q;
        edge_d     = edge_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        lsb_d      = lsb_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        mosi_d     = mosi_q;
        sclk_d     = sclk_q;
        cs_n_d     = cs_n_q;
        data_out_d = data_out_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                sclk_d = spi_cpol;
                mosi_d = 1'b0;
                cs_n_d = '1;
                busy_d = 1'b0;
                cnt_d  = '0;
                edge_d = '0;
                if (spi_start) begin
                    presc_d = spi_prescaler;
                    cpol_d  = spi_cpol;
                    cpha_d  = spi_cpha;
                    lsb_d   = spi_lsb_first;
                    cs_n_d  = cs_dec;
                    rx_d    = '0;
                    busy_d  = 1'b1;
                    state_d = ST_LEAD;
                    if (!spi_cpha) begin
                        // First bit must be on the line before the first leading edge.
                        mosi_d = first_bit(spi_data_in, spi_lsb_first);
                        tx_d   = shift_out(spi_data_in, spi_lsb_first);
                    end else begin
                        tx_d   = spi_data_in;
                    end
                end
            end

            ST_LEAD: begin
                if (tick) begin
                    cnt_d   = '0;
                    state_d = ST_XFER;
                end else begin
                    cnt_d = cnt_q + PRESC_WIDTH'(1);
                end
            end

            ST_XFER: begin
                if (tick) begin
                    cnt_d  = '0;
                    sclk_d = ~sclk_q;
                    edge_d = edge_q + EDGE_W'(1);
                    if (sample_edge) begin
                        rx_d = shift_in(rx_q, MISO, lsb_q);
                    end else if (edge_q != LAST_EDGE) begin
                        mosi_d = first_bit(tx_q, lsb_q);
                        tx_d   = shift_out(tx_q, lsb_q);
                    end
                    if (edge_q == LAST_EDGE) begin
                        edge_d  = '0;
                        state_d = ST_TRAIL;
                    end
                end else begin
                    cnt_d = cnt_q + PRESC_WIDTH'(1);
                end
            end

            ST_TRAIL: begin
                if (tick) begin
                    cnt_d      = '0;
                    cs_n_d     = '1;
                    data_out_d = rx_q;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + PRESC_WIDTH'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            presc_q    <= '0;
            edge_q     <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            lsb_q      <= 1'b0;
            tx_q       <= '0;
            rx_q       <= '0;
            mosi_q     <= 1'b0;
            sclk_q     <= 1'b0;
            cs_n_q     <= '1;
            data_out_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            presc_q    <= presc_d;
            edge_q     <= edge_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            lsb_q      <= lsb_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            mosi_q     <= mosi_d;
            sclk_q     <= sclk_d;
            cs_n_q     <= cs_n_d;
            data_out_q <= data_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign MOSI         = mosi_q;
    assign SCLK         = sclk_q;
    assign CS_N         = cs_n_q;
    assign spi_data_out = data_out_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: table of directed transfers, corner-case
// sequences and random transfers, all checked against a behavioural SPI slave.
module tb_spi_master_param;

    localparam int W   = 8;
    localparam int PW  = 8;
    localparam int NCS = 4;
    localparam int CSW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          spi_start;
    logic [W-1:0]  spi_data_in;
    logic [PW-1:0] spi_prescaler;
    logic          spi_cpol, spi_cpha, spi_lsb_first;
    logic [CSW-1:0] spi_cs_sel;
    logic          MISO;
    logic          MOSI, SCLK;
    logic [NCS-1:0] CS_N;
    logic [W-1:0]  spi_data_out;
    logic          busy, done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int dbl_done = 0;
    int exp_done = 0;
    logic prev_done = 1'b0;

    spi_master_param #(
        .DATA_WIDTH (W),
        .PRESC_WIDTH(PW),
        .NUM_CS     (NCS),
        .CS_SEL_W   (CSW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .spi_start    (spi_start),
        .spi_data_in  (spi_data_in),
        .spi_prescaler(spi_prescaler),
        .spi_cpol     (spi_cpol),
        .spi_cpha     (spi_cpha),
        .spi_lsb_first(spi_lsb_first),
        .spi_cs_sel   (spi_cs_sel),
        .MISO         (MISO),
        .MOSI         (MOSI),
        .SCLK         (SCLK),
        .CS_N         (CS_N),
        .spi_data_out (spi_data_out),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Count done pulses and detect any pulse longer than one cycle.
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            if (prev_done) dbl_done++;
        end
        prev_done = done;
    end

    typedef struct {
        logic [W-1:0]   data;
        logic [PW-1:0]  presc;
        logic           cpol;
        logic           cpha;
        logic           lsb;
        logic [CSW-1:0] cs;
        logic [W-1:0]   sword;
        logic           loopback;
        int             exp_len;
        logic [W-1:0]   exp_rx;
        logic [NCS-1:0] exp_cs;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    // Position of the n-th transmitted bit within the word.
    function automatic int pos(input int n, input logic lsb);
        return lsb ? n : (W - 1 - n);
    endfunction

    // Reference timing and chip-select, straight from the transfer rules.
    function automatic int model_len(input logic [PW-1:0] p);
        return (int'(p) + 1) * (2 * W + 2);
    endfunction

    function automatic logic [NCS-1:0] model_cs(input logic [CSW-1:0] s);
        logic [NCS-1:0] r;
        r = '1;
        if (int'(s) < NCS) r[s] = 1'b0;
        return r;
    endfunction

    // inj_kind: 0 none, 1 start pulse with new data mid-transfer,
    // 2 reset mid-transfer, 3 raise start just before done and leave it high.
    task automatic run_xfer(input string nm, input vec_t v, input int inj_kind, input int inj_cyc);
        int k, stx, srx, rises, viol, cs_bad;
        logic [W-1:0] scap;
        logic prev_sclk, prev_mosi, seen_done, aborted, lead, samp;

        spi_data_in   = v.data;
        spi_prescaler = v.presc;
        spi_cpol      = v.cpol;
        spi_cpha      = v.cpha;
        spi_lsb_first = v.lsb;
        spi_cs_sel    = v.cs;
        spi_start     = 1'b1;
        stx = 0; srx = 0; scap = '0;
        if (!v.cpha && !v.loopback) begin
            MISO = v.sword[pos(0, v.lsb)];
            stx  = 1;
        end
        @(posedge clk); #1;
        spi_start = 1'b0;
        chk({nm, "_busy_rise"}, 32'(busy), 32'd1);
        chk({nm, "_sclk_idle"}, 32'(SCLK), 32'(v.cpol));
        if (v.loopback) MISO = MOSI;
        prev_sclk = SCLK; prev_mosi = MOSI;
        k = 0; rises = 0; viol = 0; cs_bad = 0;
        seen_done = 1'b0; aborted = 1'b0;
        if (CS_N !== v.exp_cs) cs_bad++;

        while (!seen_done && !aborted && k < v.exp_len + 50) begin
            if (inj_kind == 1 && k == inj_cyc) begin
                spi_start = 1'b1; spi_data_in = 8'hFF;
            end
            if (inj_kind == 1 && k == inj_cyc + 1) spi_start = 1'b0;
            if (inj_kind == 2 && k == inj_cyc) reset = 1'b1;
            if (inj_kind == 3 && k == v.exp_len - 1) spi_start = 1'b1;
            @(posedge clk); #1;
            k++;
            if (reset) begin
                reset = 1'b0;
                aborted = 1'b1;
            end else begin
                if (SCLK !== prev_sclk) begin
                    lead = (SCLK != v.cpol);
                    samp = lead ^ v.cpha;
                    if (SCLK) rises++;
                    if (samp) begin
                        if (MOSI !== prev_mosi) viol++;
                        if (srx < W) scap[pos(srx, v.lsb)] = MOSI;
                        srx++;
                    end else begin
                        if (!v.loopback && stx < W) MISO = v.sword[pos(stx, v.lsb)];
                        stx++;
                    end
                end
                prev_sclk = SCLK; prev_mosi = MOSI;
                if (v.loopback) MISO = MOSI;
                if (done) seen_done = 1'b1;
                else if (CS_N !== v.exp_cs) cs_bad++;
            end
        end

        if (aborted) begin
            chk({nm, "_rst_csn"}, 32'(CS_N), 32'hF);
            chk({nm, "_rst_sclk"}, 32'(SCLK), 32'd0);
            chk({nm, "_rst_busy"}, 32'(busy), 32'd0);
            chk({nm, "_rst_done"}, 32'(done), 32'd0);
            chk({nm, "_rst_dout"}, 32'(spi_data_out), 32'd0);
            repeat (v.exp_len + 10) @(posedge clk);
            #1;
            chk({nm, "_rst_no_done"}, 32'(done_cnt), 32'(exp_done));
            $display("xfer %s aborted by reset at k=%0d", nm, k);
        end else if (!seen_done) begin
            checks++; errors++;
            $display("FAIL %s_timeout no done within %0d cycles (expected at %0d)",
                     nm, k, v.exp_len);
        end else begin
            exp_done++;
            chk({nm, "_latency"}, 32'(k), 32'(v.exp_len));
            chk({nm, "_data_out"}, 32'(spi_data_out), 32'(v.exp_rx));
            chk({nm, "_slave_rx"}, 32'(scap), 32'(v.data));
            chk({nm, "_cs_bad"}, 32'(cs_bad), 32'd0);
            chk({nm, "_rises"}, 32'(rises), 32'(W));
            chk({nm, "_mosi_viol"}, 32'(viol), 32'd0);
            chk({nm, "_done_busy"}, 32'(busy), 32'd0);
            chk({nm, "_done_csn"}, 32'(CS_N), 32'hF);
            $display("xfer %s data=%02h presc=%0d mode=%0d%0d lsb=%0d cs=%0d rx=%02h len=%0d",
                     nm, v.data, v.presc, v.cpol, v.cpha, v.lsb, v.cs, spi_data_out, k);
        end
    endtask

    task automatic idle_check(input string nm, input logic cpol);
        repeat (2) @(posedge clk);
        #1;
        chk({nm, "_idle_sclk"}, 32'(SCLK), 32'(cpol));
        chk({nm, "_idle_mosi"}, 32'(MOSI), 32'd0);
        chk({nm, "_idle_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        vec_t v;
        vecs[0] = '{8'hA5, 8'd0,   1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 18,   8'hA5, 4'b1110};
        vecs[1] = '{8'hC3, 8'd2,   1'b1, 1'b1, 1'b1, 3'd1, 8'h3C, 1'b0, 54,   8'h3C, 4'b1101};
        vecs[2] = '{8'h81, 8'd1,   1'b0, 1'b1, 1'b0, 3'd2, 8'h5A, 1'b0, 36,   8'h5A, 4'b1011};
        vecs[3] = '{8'h81, 8'd1,   1'b1, 1'b0, 1'b0, 3'd0, 8'h96, 1'b0, 36,   8'h96, 4'b1110};
        vecs[4] = '{8'h6E, 8'd0,   1'b0, 1'b0, 1'b1, 3'd4, 8'hF0, 1'b0, 18,   8'hF0, 4'b1111};
        vecs[5] = '{8'h39, 8'd255, 1'b0, 1'b1, 1'b1, 3'd3, 8'hC6, 1'b0, 4608, 8'hC6, 4'b0111};

        reset = 1'b1; spi_start = 1'b0; spi_data_in = '0; spi_prescaler = '0;
        spi_cpol = 1'b0; spi_cpha = 1'b0; spi_lsb_first = 1'b0; spi_cs_sel = '0; MISO = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_mosi", 32'(MOSI), 32'd0);
        chk("reset_sclk", 32'(SCLK), 32'd0);
        chk("reset_csn", 32'(CS_N), 32'hF);
        chk("reset_dout", 32'(spi_data_out), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            run_xfer($sformatf("vec%0d", i), vecs[i], 0, 0);
            idle_check($sformatf("vec%0d", i), vecs[i].cpol);
        end

        // Start pulse with different data while busy is ignored.
        v = vecs[0];
        v.loopback = 1'b0; v.sword = 8'h4B; v.exp_rx = 8'h4B;
        run_xfer("ign_start", v, 1, 5);
        idle_check("ign_start", v.cpol);

        // Reset in the middle of a transfer, then a fresh transfer.
        run_xfer("mid_reset", vecs[0], 2, 10);
        run_xfer("post_reset", vecs[0], 0, 0);
        idle_check("post_reset", vecs[0].cpol);

        // Start held across done: second transfer on cs 3 follows immediately,
        // then an out-of-range select.
        v = vecs[3];
        run_xfer("b2b_first", v, 3, 0);
        v = vecs[2]; v.cs = 3'd3; v.exp_cs = 4'b0111;
        run_xfer("b2b_second", v, 0, 0);
        v = vecs[2]; v.cs = 3'd4; v.exp_cs = 4'b1111;
        run_xfer("b2b_nocs", v, 0, 0);
        idle_check("b2b", v.cpol);

        // Random transfers against the reference model.
        for (int i = 0; i < 24; i++) begin
            v.data     = W'($urandom);
            v.presc    = PW'($urandom_range(0, 3));
            v.cpol     = 1'($urandom);
            v.cpha     = 1'($urandom);
            v.lsb      = 1'($urandom);
            v.cs       = CSW'($urandom_range(0, 7));
            v.sword    = W'($urandom);
            v.loopback = 1'($urandom);
            v.exp_len  = model_len(v.presc);
            v.exp_rx   = v.loopback ? v.data : v.sword;
            v.exp_cs   = model_cs(v.cs);
            run_xfer($sformatf("rnd%0d", i), v, 0, 0);
            if ($urandom_range(0, 1) == 1) idle_check($sformatf("rnd%0d", i), v.cpol);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("done_count", 32'(done_cnt), 32'(exp_done));
        chk("done_width", 32'(dbl_done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL global_timeout simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
